// File: rtl/serial2parallel_pkg.sv
// Shared definitions for the serial-to-parallel receiver.
//   get_width   : bits needed to hold a non-negative value (minimum 1)
//   CODE_*      : bit-order selectors for the reassembled word
//   ST_*        : receiver FSM state encodings
package serial2parallel_pkg;

   localparam int CODE_LITTLE = 0;
   localparam int CODE_BIG    = 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RECV = 1'b1;

   function automatic int get_width(input int value);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((value >> i) != 0) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/serial2parallel_sync_edge_detect.sv
// Single-bit synchroniser with rising-edge detect.
//   clk_i   : main clock
//   rst_i   : synchronous active-high reset
//   d_i     : asynchronous input
//   level_o : d_i after STAGES flops (STAGES=0 passes d_i straight through)
//   rise_o  : one-cycle pulse when level_o goes 0 -> 1
module sync_edge_detect #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o
);

   logic level_d_q;

   generate
      if (STAGES == 0) begin : g_bypass
         assign level_o = d_i;
      end else begin : g_chain
         logic [STAGES-1:0] chain_q;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               chain_q <= '0;
            end else begin
               chain_q[0] <= d_i;
               for (int i = 1; i < STAGES; i++) begin
                  chain_q[i] <= chain_q[i-1];
               end
            end
         end

         assign level_o = chain_q[STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) level_d_q <= 1'b0;
      else       level_d_q <= level_o;
   end

   assign rise_o = level_o & ~level_d_q;

endmodule

// File: rtl/serial2parallel.sv
// Serial-to-parallel receiver for the three-wire (s_clk, s_clr, s_dat) link.
// Oversamples s_clk in the clk domain and rebuilds DATA_BITS-bit words.
//   clk   : main clock
//   rst   : synchronous active-high reset
//   s_clk : serial clock, data taken on its rising edge
//   s_clr : serial clear, starts (or restarts) a frame
//   s_dat : serial data
//   data  : last completed word, held until the next completion
//   valid : one-cycle pulse, data updated in the same cycle
//   busy  : frame in progress
//   abort : one-cycle pulse when s_clr restarts a partially received frame
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for s_clr; s_clk edges ignored
// ST_RECV | collecting bits; completes on the DATA_BITS-th rise
module serial2parallel
   import serial2parallel_pkg::*;
#(
   parameter int DATA_BITS   = 32,
   parameter int CODE_ENDIAN = CODE_LITTLE,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_clk,
   input  logic                 s_clr,
   input  logic                 s_dat,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 busy,
   output logic                 abort
);

   localparam int                CNT_W    = get_width(DATA_BITS - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_BITS - 1);

   logic clk_lvl_unused;
   logic clk_rise;
   logic clr_lvl;
   logic clr_rise_unused;
   logic dat_lvl;
   logic dat_rise_unused;

   // Identical chains on all three wires keep them mutually aligned.
   sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_clk (
      .clk_i   (clk),
      .rst_i   (rst),
      .d_i     (s_clk),
      .level_o (clk_lvl_unused),
      .rise_o  (clk_rise)
   );

   sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_clr (
      .clk_i   (clk),
      .rst_i   (rst),
      .d_i     (s_clr),
      .level_o (clr_lvl),
      .rise_o  (clr_rise_unused)
   );

   sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_dat (
      .clk_i   (clk),
      .rst_i   (rst),
      .d_i     (s_dat),
      .level_o (dat_lvl),
      .rise_o  (dat_rise_unused)
   );

   logic [0:0]           state_q, state_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [DATA_BITS-1:0] sreg_q, sreg_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 abort_q, abort_d;
   logic [DATA_BITS-1:0] sreg_shift;

   generate
      if (CODE_ENDIAN == CODE_BIG) begin : g_big
         assign sreg_shift = {sreg_q[DATA_BITS-2:0], dat_lvl};
      end else begin : g_little
         assign sreg_shift = {dat_lvl, sreg_q[DATA_BITS-1:1]};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      sreg_d  = sreg_q;
      data_d  = data_q;
      valid_d = 1'b0;
      abort_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clr_lvl) begin
               state_d = ST_RECV;
               count_d = '0;
               sreg_d  = '0;
            end
         end
         ST_RECV: begin
            // Clear has priority; a coincident rise is dropped.
            if (clr_lvl) begin
               count_d = '0;
               sreg_d  = '0;
               abort_d = (count_q != '0);
            end else if (clk_rise) begin
               sreg_d = sreg_shift;
               if (count_q == CNT_LAST) begin
                  data_d  = sreg_shift;
                  valid_d = 1'b1;
                  state_d = ST_IDLE;
                  count_d = '0;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         sreg_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         sreg_q  <= sreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         abort_q <= abort_d;
      end
   end

   assign data  = data_q;
   assign valid = valid_q;
   assign busy  = (state_q == ST_RECV);
   assign abort = abort_q;

endmodule

// File: tb/tb_serial2parallel.sv
// Bench for serial2parallel: three instances share one serial stream.
//   dut 0 : 32 bits, little-endian, 2-stage synchroniser
//   dut 1 :  8 bits, big-endian,    no synchroniser
//   dut 2 :  8 bits, little-endian, no synchroniser
// A frame-level model (bit queue per receiver, word assembled at completion)
// predicts every output on every cycle; literal checks pin known words.
module tb_serial2parallel;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_clk = 1'b0;
   logic        s_clr = 1'b0;
   logic        s_dat = 1'b0;

   logic [31:0] data_a;
   logic [7:0]  data_b, data_c;
   logic        valid_a, valid_b, valid_c;
   logic        busy_a, busy_b, busy_c;
   logic        abort_a, abort_b, abort_c;

   always #5 clk = ~clk;

   serial2parallel #(.DATA_BITS(32), .CODE_ENDIAN(0), .SYNC_STAGES(2)) u_dut_a (
      .clk(clk), .rst(rst), .s_clk(s_clk), .s_clr(s_clr), .s_dat(s_dat),
      .data(data_a), .valid(valid_a), .busy(busy_a), .abort(abort_a));

   serial2parallel #(.DATA_BITS(8), .CODE_ENDIAN(1), .SYNC_STAGES(0)) u_dut_b (
      .clk(clk), .rst(rst), .s_clk(s_clk), .s_clr(s_clr), .s_dat(s_dat),
      .data(data_b), .valid(valid_b), .busy(busy_b), .abort(abort_b));

   serial2parallel #(.DATA_BITS(8), .CODE_ENDIAN(0), .SYNC_STAGES(0)) u_dut_c (
      .clk(clk), .rst(rst), .s_clk(s_clk), .s_clr(s_clr), .s_dat(s_dat),
      .data(data_c), .valid(valid_c), .busy(busy_c), .abort(abort_c));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int nb(input int d);
      return (d == 0) ? 32 : 8;
   endfunction
   function automatic int endian(input int d);
      return (d == 1) ? 1 : 0;
   endfunction
   function automatic int stages(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   // raw input history: index j holds the value sampled j edges ago
   bit          hclk[5], hclr[5], hdat[5];
   bit          m_active[3];
   int          m_n[3];
   bit          m_bits[3][32];
   logic [31:0] m_data[3];
   bit          m_valid[3], m_abort[3], m_busy[3];

   bit chk_en   = 1'b0;
   bit mon_busy = 1'b0;
   int cnt_valid[3];
   int cnt_abort[3];
   int busy_low_a;
   int bad_fall_a;
   bit prev_busy_a;

   task automatic clear_counts();
      for (int d = 0; d < 3; d++) begin
         cnt_valid[d] = 0;
         cnt_abort[d] = 0;
      end
      busy_low_a = 0;
      bad_fall_a = 0;
   endtask

   initial begin
      logic [31:0] act_data[3];
      bit          act_valid[3], act_busy[3], act_abort[3];
      logic [31:0] word;
      int          s;
      bit          lvl, prv, clr, dat;
      forever begin
         @(posedge clk);
         for (int j = 4; j > 0; j--) begin
            hclk[j] = hclk[j-1];
            hclr[j] = hclr[j-1];
            hdat[j] = hdat[j-1];
         end
         hclk[0] = s_clk;
         hclr[0] = s_clr;
         hdat[0] = s_dat;
         if (rst) begin
            for (int j = 0; j < 5; j++) begin
               hclk[j] = 1'b0;
               hclr[j] = 1'b0;
               hdat[j] = 1'b0;
            end
            for (int d = 0; d < 3; d++) begin
               m_active[d] = 1'b0;
               m_n[d]      = 0;
               m_data[d]   = '0;
               m_valid[d]  = 1'b0;
               m_abort[d]  = 1'b0;
               m_busy[d]   = 1'b0;
            end
         end else begin
            for (int d = 0; d < 3; d++) begin
               s   = stages(d);
               lvl = hclk[s];
               prv = hclk[s+1];
               clr = hclr[s];
               dat = hdat[s];
               m_valid[d] = 1'b0;
               m_abort[d] = 1'b0;
               if (clr) begin
                  if (m_active[d] && m_n[d] != 0) m_abort[d] = 1'b1;
                  m_active[d] = 1'b1;
                  m_n[d]      = 0;
               end else if (m_active[d] && lvl && !prv) begin
                  m_bits[d][m_n[d]] = dat;
                  m_n[d]++;
                  if (m_n[d] == nb(d)) begin
                     word = '0;
                     for (int i = 0; i < nb(d); i++) begin
                        if (endian(d) == 0) word[i] = m_bits[d][i];
                        else                word[nb(d)-1-i] = m_bits[d][i];
                     end
                     m_data[d]   = word;
                     m_valid[d]  = 1'b1;
                     m_active[d] = 1'b0;
                     m_n[d]      = 0;
                  end
               end
               m_busy[d] = m_active[d];
            end
         end

         @(negedge clk);
         act_data[0] = data_a;          act_data[1] = {24'b0, data_b};  act_data[2] = {24'b0, data_c};
         act_valid[0] = valid_a;        act_valid[1] = valid_b;         act_valid[2] = valid_c;
         act_busy[0] = busy_a;          act_busy[1] = busy_b;           act_busy[2] = busy_c;
         act_abort[0] = abort_a;        act_abort[1] = abort_b;         act_abort[2] = abort_c;
         if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
               chk($sformatf("data%0d", d),  act_data[d],  m_data[d]);
               chk($sformatf("valid%0d", d), {31'b0, act_valid[d]}, {31'b0, m_valid[d]});
               chk($sformatf("busy%0d", d),  {31'b0, act_busy[d]},  {31'b0, m_busy[d]});
               chk($sformatf("abort%0d", d), {31'b0, act_abort[d]}, {31'b0, m_abort[d]});
               if (act_valid[d]) cnt_valid[d]++;
               if (act_abort[d]) cnt_abort[d]++;
            end
            if (mon_busy && !busy_a) busy_low_a++;
            if (valid_a && !(prev_busy_a && !busy_a)) bad_fall_a++;
         end
         prev_busy_a = busy_a;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input bit b, input int lo, input int hi);
      s_dat = b;
      cyc(lo);
      s_clk = 1'b1;
      cyc(hi);
      s_clk = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] w, input int from, input int to, input int lo, input int hi);
      for (int i = from; i <= to; i++) send_bit(w[i], lo, hi);
   endtask

   task automatic send_bits_rand(input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) send_bit(w[i], $urandom_range(2, 4), $urandom_range(2, 4));
   endtask

   task automatic clr_pulse(input int len);
      s_clr = 1'b1;
      cyc(len);
      s_clr = 1'b0;
      cyc(2);
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] w;
      int          r;
      clear_counts();
      cyc(3);
      rst = 1'b0;
      chk_en = 1'b1;
      chk("reset_data_a", data_a, 32'h0);
      chk("reset_busy_a", {31'b0, busy_a}, 32'h0);

      // 1: 10x oversampled frame
      clear_counts();
      clr_pulse(1);
      send_bits(32'hA5C30F81, 0, 31, 5, 5);
      cyc(6);
      chk("t1_data_a", data_a, 32'hA5C30F81);
      chk("t1_valid_cnt_a", cnt_valid[0], 1);
      chk("t1_abort_cnt_a", cnt_abort[0], 0);
      chk("t1_busy_fall_a", bad_fall_a, 0);
      chk("t1_data_b", {24'b0, data_b}, 32'h81);

      // 2: eight bits 0,0,0,1,1,1,1,1
      clear_counts();
      clr_pulse(1);
      send_bits(32'h000000F8, 0, 7, 2, 2);
      cyc(6);
      chk("t2_data_b", {24'b0, data_b}, 32'h1F);
      chk("t2_data_c", {24'b0, data_c}, 32'hF8);
      chk("t2_valid_cnt_b", cnt_valid[1], 1);
      chk("t2_busy_a", {31'b0, busy_a}, 32'h1);
      rst_pulse();
      cyc(1);

      // 3: restart after 5 bits
      clear_counts();
      clr_pulse(1);
      cyc(1);
      mon_busy = 1'b1;
      send_bits(32'h00000016, 0, 4, 2, 3);
      clr_pulse(1);
      send_bits(32'h12345678, 0, 30, 2, 3);
      mon_busy = 1'b0;
      send_bits(32'h12345678, 31, 31, 2, 3);
      cyc(6);
      chk("t3_abort_cnt_a", cnt_abort[0], 1);
      chk("t3_abort_cnt_c", cnt_abort[2], 1);
      chk("t3_busy_low_a", busy_low_a, 0);
      chk("t3_valid_cnt_a", cnt_valid[0], 1);
      chk("t3_data_a", data_a, 32'h12345678);
      chk("t3_data_b", {24'b0, data_b}, 32'h1E);
      chk("t3_data_c", {24'b0, data_c}, 32'h78);

      // 4: idle toggling without s_clr
      clear_counts();
      for (int i = 0; i < 40; i++) send_bit(1'($urandom), 2, $urandom_range(2, 3));
      cyc(6);
      chk("t4_valid_cnt_a", cnt_valid[0], 0);
      chk("t4_valid_cnt_b", cnt_valid[1], 0);
      chk("t4_busy_a", {31'b0, busy_a}, 32'h0);
      chk("t4_data_a", data_a, 32'h12345678);
      chk("t4_data_c", {24'b0, data_c}, 32'h78);

      // 5: reset mid-frame
      clr_pulse(1);
      send_bits($urandom, 0, 9, 2, 2);
      cyc(2);
      rst_pulse();
      chk("t5_data_a", data_a, 32'h0);
      chk("t5_data_b", {24'b0, data_b}, 32'h0);
      chk("t5_busy_a", {31'b0, busy_a}, 32'h0);
      chk("t5_valid_a", {31'b0, valid_a}, 32'h0);
      clear_counts();
      send_bits(32'h0000001F, 0, 4, 2, 2);
      cyc(6);
      chk("t5_idle_valid_cnt_a", cnt_valid[0], 0);
      chk("t5_idle_busy_a", {31'b0, busy_a}, 32'h0);
      clr_pulse(2);
      send_bits_rand(32'hDEADBEEF, 32);
      cyc(6);
      chk("t5_data_a", data_a, 32'hDEADBEEF);
      chk("t5_data_b2", {24'b0, data_b}, 32'hF7);
      chk("t5_data_c2", {24'b0, data_c}, 32'hEF);

      // 6: clear coinciding with a rise
      clear_counts();
      clr_pulse(1);
      send_bits(32'h00000005, 0, 2, 2, 2);
      s_dat = 1'b1;
      cyc(2);
      s_clr = 1'b1;
      s_clk = 1'b1;
      cyc(2);
      s_clr = 1'b0;
      cyc(1);
      s_clk = 1'b0;
      cyc(1);
      send_bits(32'h0F0F1234, 0, 31, 2, 2);
      cyc(6);
      chk("t6_abort_cnt_a", cnt_abort[0], 1);
      chk("t6_valid_cnt_a", cnt_valid[0], 1);
      chk("t6_data_a", data_a, 32'h0F0F1234);
      chk("t6_data_b", {24'b0, data_b}, 32'h2C);
      chk("t6_data_c", {24'b0, data_c}, 32'h34);

      // random frames, aborts and resets, checked by the model each cycle
      for (int k = 0; k < 25; k++) begin
         w = $urandom;
         clr_pulse($urandom_range(1, 3));
         r = $urandom_range(0, 7);
         if (r == 0) begin
            send_bits_rand(w, $urandom_range(1, 20));
         end else if (r == 1) begin
            send_bits_rand(w, $urandom_range(1, 20));
            cyc($urandom_range(0, 3));
            rst_pulse();
         end else begin
            send_bits_rand(w, 32);
            cyc($urandom_range(3, 8));
            chk("rand_data_a", data_a, w);
         end
      end
      cyc(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
